// File: rtl/parity_nibble_rx.sv
// parity_nibble_rx
//   Serial receiver for 4-bit nibbles that carry one XOR parity bit.
//   The frame on an idle-high line is: start(0), d3, d2, d1, d0 (MSB first),
//   parity, stop(1).
//   The receiver rebuilds the nibble, recomputes the parity and reports both
//   parity errors and framing (stop-bit) errors.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2 or more)
//   ODD_PARITY   : 0 = even parity, 1 = odd parity
//
// Ports
//   clk        : single clock; all state updates on the rising edge
//   reset      : asynchronous, active-high; clears all state immediately
//   rx         : serial line, asynchronous to clk, idles high
//   data       : last received nibble, held until the next frame completes
//   valid      : one-cycle pulse when a frame completes (good or bad)
//   parity_err : parity mismatch on the last frame, held with data
//   frame_err  : stop bit sampled low on the last frame, held with data
//   busy       : high whenever the receiver is not idle
module parity_nibble_rx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          ODD_PARITY   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [3:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    bitcnt, bitcnt_nxt;
    logic [3:0]    shreg, shreg_nxt;
    logic          perr, perr_nxt;
    logic [3:0]    data_nxt;
    logic          valid_nxt;
    logic          parity_err_nxt;
    logic          frame_err_nxt;

    // Two-flop synchronizer.
    // The flops reset to the idle level so that a reset cannot fake a start bit.
    logic rx_meta, rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bitcnt     <= bitcnt_nxt;
            shreg      <= shreg_nxt;
            perr       <= perr_nxt;
            data       <= data_nxt;
            valid      <= valid_nxt;
            parity_err <= parity_err_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bitcnt_nxt     = bitcnt;
        shreg_nxt      = shreg;
        perr_nxt       = perr;
        data_nxt       = data;
        valid_nxt      = 1'b0;
        parity_err_nxt = parity_err;
        frame_err_nxt  = frame_err;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = START;
                end
            end

            // Re-check the start bit at its middle.
            // A line that is already high again at that point was a glitch.
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt    = '0;
                    bitcnt_nxt = '0;
                    state_nxt  = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt    = '0;
                    shreg_nxt  = {shreg[2:0], rx_s};
                    bitcnt_nxt = bitcnt + 2'd1;
                    if (bitcnt == 2'd3) begin
                        state_nxt = PARITY;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    perr_nxt  = ((^shreg) ^ rx_s) != ODD_PARITY;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            // The result is published even when the frame has errors.
            // A low stop bit means the line may be in a break, so the receiver
            // waits for the line to go high before it arms again.
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt        = '0;
                    data_nxt       = shreg;
                    parity_err_nxt = perr;
                    frame_err_nxt  = ~rx_s;
                    valid_nxt      = 1'b1;
                    state_nxt      = rx_s ? IDLE : WAIT_HIGH;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            WAIT_HIGH: begin
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_nibble_rx.sv
// tb_parity_nibble_rx
//   Scoreboard bench for parity_nibble_rx (CLKS_PER_BIT=4, even parity).
//   The stimulus tasks push the expected frame result when they send a frame.
//   The monitor pops the queue and compares it against every valid pulse.
module tb_parity_nibble_rx;

    localparam int unsigned CPB = 4;
    localparam bit          ODD = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [3:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    parity_nibble_rx #(
        .CLKS_PER_BIT (CPB),
        .ODD_PARITY   (ODD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    bit   prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected outcome of a frame, derived directly from the bits on the line.
    // With even parity, a correct frame has an even number of ones across the
    // nibble and the parity bit.
    function automatic exp_t model(input logic [3:0] nib, input logic p, input logic stop);
        exp_t e;
        int   ones;
        ones = $countones(nib) + int'(p);
        e.d  = nib;
        e.pe = ((ones % 2) == 1) != ODD;
        e.fe = (stop == 1'b0);
        return e;
    endfunction

    // Monitor process: samples the DUT outputs on the falling edge of clk.
    always @(negedge clk) begin
        if (reset) begin
            check("valid_in_reset", valid, 0);
        end else if (valid) begin
            if (prev_valid) begin
                check("valid_width", 2, 1);
            end
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("data", data, mon_e.d);
                check("parity_err", parity_err, mon_e.pe);
                check("frame_err", frame_err, mon_e.fe);
            end
        end
        prev_valid = valid;
    end

    // Drives one bit level for n clock cycles.
    // It is called at a falling edge of clk.
    task automatic hold_bit(input logic v, input int unsigned n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] nib, input logic p, input logic stop,
                              input int unsigned low_extra, input int unsigned idle_after);
        exp_q.push_back(model(nib, p, stop));
        hold_bit(1'b0, CPB);
        for (int i = 3; i >= 0; i--) begin
            hold_bit(nib[i], CPB);
        end
        hold_bit(p, CPB);
        hold_bit(stop, CPB);
        if (!stop) begin
            hold_bit(1'b0, low_extra);
        end
        if (idle_after > 0) begin
            hold_bit(1'b1, idle_after);
        end
    endtask

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  nib;
        logic        p;
        logic        stop;
        int unsigned low_extra;
        int unsigned idle;
        int unsigned order[16];

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 0);

        // All 16 nibbles with correct even parity, in a random order.
        for (int i = 0; i < 16; i++) begin
            order[i] = i;
        end
        for (int i = 15; i > 0; i--) begin
            int unsigned j;
            int unsigned t;
            j        = $urandom_range(i, 0);
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 16; i++) begin
            nib = order[i][3:0];
            send_frame(nib, ^nib, 1'b1, 0, $urandom_range(4, 1));
        end
        drain("sweep_drain");

        // A parity error, then a good frame that clears the parity_err flag.
        send_frame(4'b0011, 1'b1, 1'b1, 0, 4);
        send_frame(4'b0001, 1'b1, 1'b1, 0, 4);
        drain("parity_drain");

        // A framing error with the line held low afterwards (a break).
        send_frame(4'b0101, 1'b0, 1'b0, 12, 0);
        check("break_busy", busy, 1);
        hold_bit(1'b1, 8);
        check("break_busy_release", busy, 0);
        drain("break_drain");
        hold_bit(1'b1, 10);
        check("break_no_extra", exp_q.size(), 0);

        // A single-cycle low glitch must not be received as a frame.
        hold_bit(1'b0, 1);
        hold_bit(1'b1, 6);
        check("glitch_busy", busy, 0);
        hold_bit(1'b1, 6);

        // Leave non-zero held outputs, then reset in the middle of bit d1.
        send_frame(4'b1010, 1'b1, 1'b1, 0, 4);
        drain("pre_reset_drain");
        hold_bit(1'b0, CPB);
        hold_bit(1'b1, CPB);
        hold_bit(1'b1, CPB);
        rx = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_data", data, 0);
        check("midrst_valid", valid, 0);
        check("midrst_perr", parity_err, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hold_bit(1'b1, 6);
        send_frame(4'b1110, 1'b1, 1'b1, 0, 4);
        drain("post_reset_drain");

        // Back-to-back frames: the second start bit follows the first stop bit directly.
        send_frame(4'b1000, 1'b1, 1'b1, 0, 0);
        send_frame(4'b0111, 1'b1, 1'b1, 0, 4);
        drain("b2b_drain");

        // Random frames with random parity, stop bit and gaps.
        for (int k = 0; k < 24; k++) begin
            nib  = 4'($urandom_range(15, 0));
            p    = 1'($urandom_range(1, 0));
            stop = ($urandom_range(3, 0) != 0);
            if (stop) begin
                low_extra = 0;
                idle      = $urandom_range(3, 0);
            end else begin
                low_extra = $urandom_range(12, 0);
                idle      = $urandom_range(5, 2);
            end
            send_frame(nib, p, stop, low_extra, idle);
        end
        hold_bit(1'b1, 4);
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parity_nibble_rx.md
Name: parity_nibble_rx

Overview:
- Serial receiver for 4-bit nibbles protected by a single XOR parity bit.
- Decode-side counterpart of the 4-input XOR parity generator: it reconstructs the nibble from a serial line, recomputes the 4-input XOR and flags mismatches.
- Sits between an external/async serial pin and parallel consumer logic.
- Frame, idle-high line: start (0), d3, d2, d1, d0 (MSB first), parity, stop (1).

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range is 2 or more; counters sized $clog2(CLKS_PER_BIT).
- ODD_PARITY, 0, 0 = even parity (parity bit = d3^d2^d1^d0); 1 = odd parity (inverted).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- rx  input  1  serial line, asynchronous to clk, idles high.
- data  output  4  last received nibble, held until next frame completes.
- valid  output  1  one-cycle pulse when a frame completes (good or bad).
- parity_err  output  1  parity mismatch on last frame; held with data.
- frame_err  output  1  stop bit sampled 0 on last frame; held with data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values: data=0, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, counters=0, synchronizer flops=1.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, adding 2 cycles of input latency.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: when rx_s==0, go to START with cnt=0.
- START: cnt increments. At cnt==CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
  - rx_s==0: go to DATA with cnt=0, bitcnt=0.
  - rx_s==1: glitch; go to IDLE and produce no valid.
- DATA: sample at cnt==CLKS_PER_BIT-1, then clear cnt.
  - Shift into shift register MSB first: shreg <= {shreg[2:0], rx_s}.
  - After the 4th sample (bitcnt==3), go to PARITY.
- PARITY: sample at cnt==CLKS_PER_BIT-1. Store perr = (^shreg ^ rx_s) != ODD_PARITY. Go to STOP.
- STOP: sample at cnt==CLKS_PER_BIT-1. On the next clock:
  - data<=shreg, parity_err<=perr, frame_err<=~rx_s, valid<=1 for exactly one cycle.
  - Next state: IDLE if rx_s==1, else WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break or stuck-low line from being taken as a new start bit.
- A frame with errors still updates data and pulses valid. The consumer decides whether to discard it.
- Back-to-back frames: a start edge arriving in the cycle immediately after STOP is accepted. IDLE detects it with no dead cycle.
- valid never asserts twice for one frame. It is never asserted during reset or in the cycle reset deasserts.
- Reset mid-frame: partial frame is discarded, outputs return to reset values, and no valid is emitted.
- Overall latency: the valid pulse occurs 2 (sync) + 1 (register) cycles after the stop-bit sample point.

Test Plan (CLKS_PER_BIT=4, ODD_PARITY=0, each bit held 4 cycles, idle high between frames):
- Sweep all 16 nibbles 0000..1111, each with correct even parity (e.g. 1011 with p=1, 1100 with p=0) -> each frame gives one valid pulse, data equals the nibble, parity_err=0, frame_err=0.
- Nibble 0011 sent with p=1 -> valid, data=4'b0011, parity_err=1, frame_err=0. The next good frame 0001 with p=1 clears parity_err to 0.
- Nibble 0101 with p=0 and stop bit 0, line held low 12 more cycles, then high -> valid with data=4'b0101, frame_err=1. busy stays high until rx_s returns high, and no spurious second frame is received.
- rx pulsed low for 1 cycle, then high -> no valid, busy returns to 0 within 4 cycles of the pulse.
- reset asserted asynchronously (mid-clock) during the DATA bit of d1 -> all outputs become 0 immediately. A fresh frame 1110 with p=1 afterwards is received correctly.
- Two frames 1000 (p=1) then 0111 (p=1), with the second start bit immediately following the first stop bit -> two valid pulses, data=1000 then 0111, no errors.
